// File: rtl/comp_bist_pkg.sv
// rtl/comp_bist_pkg.sv - shared types and constants for the comparator BIST
package comp_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Bit positions within the 3-bit {eq,gt,lt} flag vector.
    localparam int FLAG_EQ = 2;
    localparam int FLAG_GT = 1;
    localparam int FLAG_LT = 0;

    localparam int DEF_WIDTH         = 2;
    localparam int DEF_SETTLE_CYCLES = 1;

endpackage

// File: rtl/comp_golden.sv
// rtl/comp_golden.sv - combinational reference magnitude comparator
//
// Ports:
//   a, b   operands (unsigned, WIDTH bits)
//   flags  expected {eq,gt,lt}, exactly one bit set
module comp_golden
    import comp_bist_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       flags
);

    always_comb begin
        flags          = 3'b000;
        flags[FLAG_EQ] = (a == b);
        flags[FLAG_GT] = (a > b);
        flags[FLAG_LT] = (a < b);
    end

endmodule

// File: rtl/comp_bist_2b.sv
// rtl/comp_bist_2b.sv - self-test driver/checker for a magnitude comparator
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   begin a sweep (honoured only in IDLE)
//   a_out, b_out            operands driven to the comparator under test
//   a_eq_b, a_gt_b, a_lt_b  comparator responses
//   busy, done, pass        sweep status; done is a one-cycle pulse
//   err_count               failing vectors, saturating at 2^(2*WIDTH)
//   fail_valid, fail_a, fail_b, fail_flags  first-failure capture
module comp_bist_2b
    import comp_bist_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic               a_eq_b,
    input  logic               a_gt_b,
    input  logic               a_lt_b,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               fail_valid,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic [2:0]         fail_flags
);

    localparam int IW = 2 * WIDTH;
    localparam int CW = 2 * WIDTH + 1;
    localparam logic [CW-1:0] ERR_MAX     = {1'b1, {IW{1'b0}}};
    // Counter is loaded with N-1 so SETTLE lasts exactly N cycles.
    localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t          state, state_n;
    logic [IW-1:0]   idx, idx_n;
    logic [3:0]      cnt, cnt_n;
    logic            busy_n, done_n, pass_n, fv_n;
    logic [CW-1:0]   err_n;
    logic [WIDTH-1:0] fa_n, fb_n;
    logic [2:0]      ff_n;
    logic [2:0]      expected;
    logic [2:0]      observed;
    logic            mismatch;

    assign a_out = idx[IW-1:WIDTH];
    assign b_out = idx[WIDTH-1:0];

    comp_golden #(.WIDTH(WIDTH)) u_golden (
        .a     (a_out),
        .b     (b_out),
        .flags (expected)
    );

    always_comb begin
        observed          = 3'b000;
        observed[FLAG_EQ] = a_eq_b;
        observed[FLAG_GT] = a_gt_b;
        observed[FLAG_LT] = a_lt_b;
    end

    // Golden flags are one-hot, so a plain inequality also catches
    // responses with zero or several bits set.
    assign mismatch = (observed != expected);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        busy_n  = busy;
        done_n  = 1'b0;
        pass_n  = pass;
        err_n   = err_count;
        fv_n    = fail_valid;
        fa_n    = fail_a;
        fb_n    = fail_b;
        ff_n    = fail_flags;
        case (state)
            IDLE: begin
                if (start) begin
                    err_n   = '0;
                    pass_n  = 1'b0;
                    fv_n    = 1'b0;
                    fa_n    = '0;
                    fb_n    = '0;
                    ff_n    = 3'b000;
                    idx_n   = '0;
                    cnt_n   = SETTLE_LOAD;
                    busy_n  = 1'b1;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) state_n = CHECK;
                else             cnt_n   = cnt - 4'd1;
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_count != ERR_MAX) err_n = err_count + CW'(1);
                    if (!fail_valid) begin
                        fv_n = 1'b1;
                        fa_n = a_out;
                        fb_n = b_out;
                        ff_n = observed;
                    end
                end
                if (&idx) begin
                    // pass uses the count including this last vector.
                    state_n = FINISH;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    pass_n  = (err_n == '0);
                end else begin
                    idx_n   = idx + IW'(1);
                    cnt_n   = SETTLE_LOAD;
                    state_n = SETTLE;
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_flags <= 3'b000;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            busy       <= busy_n;
            done       <= done_n;
            pass       <= pass_n;
            err_count  <= err_n;
            fail_valid <= fv_n;
            fail_a     <= fa_n;
            fail_b     <= fb_n;
            fail_flags <= ff_n;
        end
    end

endmodule

// File: tb/tb_comp_bist_2b.sv
// tb/tb_comp_bist_2b.sv - self-checking bench for comp_bist_2b
module tb_comp_bist_2b;

    typedef struct {
        int lat;
        int pass;
        int errc;
        int fv;
        int fa;
        int fb;
        int ff;
    } exp_t;

    exp_t exp_q[$];

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic sel;
    int   fault;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    logic [1:0] a1, b1, fa1, fb1, a3, b3, fa3, fb3;
    logic       busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
    logic [4:0] err1, err3;
    logic [2:0] ff1, ff3, r1, r3;
    logic       start1, start3;

    // Comparator under test, with optional planted faults.
    function automatic logic [2:0] dut_resp(input logic [1:0] a, input logic [1:0] b, input int f);
        logic [2:0] r;
        r = {a == b, a > b, a < b};
        case (f)
            1: r[1] = 1'b0;
            2: r[2] = 1'b1;
            3: r = 3'b000;
            default: ;
        endcase
        return r;
    endfunction

    assign r1 = dut_resp(a1, b1, fault);
    assign r3 = dut_resp(a3, b3, fault);
    assign start1 = start & ~sel;
    assign start3 = start & sel;

    comp_bist_2b #(.WIDTH(2), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1),
        .a_eq_b(r1[2]), .a_gt_b(r1[1]), .a_lt_b(r1[0]),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1), .fail_flags(ff1)
    );

    comp_bist_2b #(.WIDTH(2), .SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a_out(a3), .b_out(b3),
        .a_eq_b(r3[2]), .a_gt_b(r3[1]), .a_lt_b(r3[0]),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_valid(fv3), .fail_a(fa3), .fail_b(fb3), .fail_flags(ff3)
    );

    logic [1:0] a_s, b_s, fa_s, fb_s;
    logic       busy_s, done_s, pass_s, fv_s;
    logic [4:0] err_s;
    logic [2:0] ff_s;
    assign a_s    = sel ? a3 : a1;
    assign b_s    = sel ? b3 : b1;
    assign fa_s   = sel ? fa3 : fa1;
    assign fb_s   = sel ? fb3 : fb1;
    assign busy_s = sel ? busy3 : busy1;
    assign done_s = sel ? done3 : done1;
    assign pass_s = sel ? pass3 : pass1;
    assign fv_s   = sel ? fv3 : fv1;
    assign err_s  = sel ? err3 : err1;
    assign ff_s   = sel ? ff3 : ff1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_model(input int f, input int sc);
        exp_t e;
        logic [1:0] a, b;
        logic [2:0] g, o;
        e = '{lat: 16 * (sc + 1), pass: 0, errc: 0, fv: 0, fa: 0, fb: 0, ff: 0};
        for (int i = 0; i < 16; i++) begin
            a = 2'(i >> 2);
            b = 2'(i & 3);
            g = {a == b, a > b, a < b};
            o = dut_resp(a, b, f);
            if (o != g) begin
                if (e.errc < 16) e.errc++;
                if (e.fv == 0) begin
                    e.fv = 1;
                    e.fa = int'(a);
                    e.fb = int'(b);
                    e.ff = int'(o);
                end
            end
        end
        e.pass = (e.errc == 0) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    task automatic run_sweep(input int f, input bit use3, input int repulse_at);
        int sc, per, total, k, idx;
        exp_t e;
        sc    = use3 ? 3 : 1;
        per   = sc + 1;
        total = 16 * per;
        fault = f;
        sel   = use3;
        push_model(f, sc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done_s && k < total + 20) begin
            if (k < total) begin
                idx = k / per;
                check_eq("busy_in_sweep", busy_s, 1);
                check_eq("a_out_step", a_s, idx >> 2);
                check_eq("b_out_step", b_s, idx & 3);
            end
            if (k == repulse_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            k++;
        end
        e = exp_q.pop_front();
        check_eq("done_latency", k, e.lat);
        check_eq("pass", pass_s, e.pass);
        check_eq("err_count", err_s, e.errc);
        check_eq("fail_valid", fv_s, e.fv);
        check_eq("fail_a", fa_s, e.fa);
        check_eq("fail_b", fb_s, e.fb);
        check_eq("fail_flags", ff_s, e.ff);
        check_eq("busy_at_done", busy_s, 0);
        // start coinciding with done must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("single_done", done_s, 0);
        check_eq("start_at_done_ignored", busy_s, 0);
        repeat (4) begin
            @(negedge clk);
            check_eq("no_extra_done", done_s, 0);
        end
        check_eq("err_count_held", err_s, e.errc);
        check_eq("pass_held", pass_s, e.pass);
    endtask

    task automatic reset_mid_sweep();
        sel   = 1'b0;
        fault = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        // vectors 0..6 checked so far; a!=b for idx 1,2,3,4,6
        check_eq("err_before_reset", err1, 5);
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", busy1, 0);
        check_eq("rst_done", done1, 0);
        check_eq("rst_pass", pass1, 0);
        check_eq("rst_err", err1, 0);
        check_eq("rst_fv", fv1, 0);
        check_eq("rst_fail", {fa1, fb1, ff1}, 0);
        check_eq("rst_ab", {a1, b1}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("no_resume_after_reset", busy1, 0);
        check_eq("ab_idle_after_reset", {a1, b1}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sel   = 1'b0;
        fault = 0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", busy1, 0);
        check_eq("reset_done", done1, 0);
        check_eq("reset_pass", pass1, 0);
        check_eq("reset_err", err1, 0);
        check_eq("reset_fv", fv1, 0);
        check_eq("reset_ab", {a1, b1}, 0);
        check_eq("reset_busy3", busy3, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(0, 1'b0, -1);
        run_sweep(1, 1'b0, -1);
        run_sweep(2, 1'b0, -1);
        run_sweep(3, 1'b0, -1);
        run_sweep(0, 1'b0, 10);
        reset_mid_sweep();
        run_sweep(0, 1'b0, -1);
        run_sweep(0, 1'b1, -1);
        run_sweep(1, 1'b1, -1);

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/comp_bist_2b.md
Name: comp_bist_2b

Overview:
Sequential built-in self-test driver/checker for the 2-bit magnitude comparator.
- Drives every operand pair (a,b) onto the comparator inputs.
- Samples the comparator's a_eq_b / a_gt_b / a_lt_b responses and checks them against an internal golden model.
- Reports pass/fail, the error count and the first failing vector.
- Sits beside the comparator as its stimulus and response end, in place of a simulation-only bench, and is usable on silicon.

Parameters:
WIDTH, 2, operand width in bits; sweep covers 2^(2*WIDTH) vectors
SETTLE_CYCLES, 1, cycles each vector is held before its response is sampled (range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled only in IDLE
a_out  output  WIDTH  operand a driven to the comparator
b_out  output  WIDTH  operand b driven to the comparator
a_eq_b  input  1  comparator response: a==b
a_gt_b  input  1  comparator response: a>b
a_lt_b  input  1  comparator response: a<b
busy  output  1  high from the start edge until done
done  output  1  one-cycle pulse when the sweep completes
pass  output  1  high after a sweep with zero errors
err_count  output  2*WIDTH+1  number of failing vectors, saturating
fail_valid  output  1  first-failure capture holds data
fail_a  output  WIDTH  a of the first failing vector
fail_b  output  WIDTH  b of the first failing vector
fail_flags  output  3  observed {eq,gt,lt} at the first failure

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs and registers go to 0 and state goes to IDLE, including mid-sweep. Sweep resumes only on a new start after release.
- States: IDLE, SETTLE, CHECK, FINISH.
- IDLE:
  - On start=1: clear err_count, pass and fail_*; set idx=0; drive a_out=0, b_out=0; set busy=1; go to SETTLE.
  - Vector index idx is 2*WIDTH bits: a_out=idx[2W-1:W], b_out=idx[W-1:0].
- SETTLE: hold the vector for SETTLE_CYCLES cycles (down-counter), then go to CHECK.
- CHECK (one cycle):
  - Compare the sampled inputs against expected {a==b, a>b, a<b}, unsigned.
  - Any mismatch is an error, including not-exactly-one-hot responses.
  - On error: err_count increments, saturating at 2^(2W). If fail_valid=0, capture fail_a/fail_b/fail_flags and set fail_valid=1.
  - If idx is all-ones, go to FINISH. Otherwise increment idx, update a_out/b_out on the same edge, and go to SETTLE.
- FINISH (one cycle): done=1, busy=0, pass=(err_count==0); go to IDLE.
- Held until the next start: pass, err_count and fail_*.
- Latency: each vector takes SETTLE_CYCLES+1 cycles. done is asserted (SETTLE_CYCLES+1)*2^(2W) cycles after the start edge; 32 for the default parameters.
- start while busy is ignored. start in the same cycle as done is ignored; start is honoured from the next cycle, once in IDLE.
- The responses are combinational from a_out/b_out. No handshake; SETTLE_CYCLES covers the propagation delay.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package comp_bist_pkg:
  - state enum {IDLE, SETTLE, CHECK, FINISH}
  - FLAG_EQ/FLAG_GT/FLAG_LT bit indices for the 3-bit flag vector
  - default WIDTH and SETTLE_CYCLES constants
- Sub-module comp_golden: purely combinational reference comparator (WIDTH parameter) producing the expected flags. It is instantiated once inside comp_bist_2b.

Test Plan:
- Correct comparator attached, start pulse -> done pulse 32 cycles after start; pass=1, err_count=0, fail_valid=0; a_out/b_out step 00/00 .. 11/11 in order.
- Faulty comparator with a_gt_b stuck at 0 -> err_count=6, pass=0, fail_a=01, fail_b=00, fail_flags=000.
- Faulty comparator with a_eq_b stuck at 1 -> err_count=12, first failure fail_a=00, fail_b=01, fail_flags=101.
- start re-pulsed at cycle 10 of a sweep -> ignored; done still arrives at cycle 32, with a single done pulse.
- rst_n low at cycle 15 of a sweep -> all outputs 0 immediately (asynchronous); start after release gives a full fresh 32-cycle sweep with pass=1.
- SETTLE_CYCLES=3, correct comparator -> done at cycle 64; each vector held 4 cycles; pass=1.
